// File: rtl/ecc_load_decoder.sv
// SECDED(39,32) load-path decoder and scrubber for the data cache.
// Checks each array read against its stored parity, returns corrected data
// with CE/UE flags, writes corrected words back, and keeps error counters.
module ecc_load_decoder #(
    parameter int unsigned CNT_W    = 16,
    parameter bit          SCRUB_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       in_addr,
    input  logic [31:0]      in_data,
    input  logic [6:0]       in_parity,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic             out_ce,
    output logic             out_ue,
    output logic             scrub_we,
    output logic [8:0]       scrub_addr,
    output logic [31:0]      scrub_din,
    output logic [6:0]       scrub_pin,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] ce_cnt,
    output logic [CNT_W-1:0] ue_cnt,
    output logic             ue_sticky
);

    typedef enum logic {IDLE, SCRUB} state_t;

    // Hamming position (3,5,6,7,9..38) occupied by data bit j.
    function automatic logic [5:0] data_pos(input int unsigned j);
        int unsigned cnt = 0;
        logic [5:0]  res = '0;
        for (int unsigned p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == j) res = p[5:0];
                cnt++;
            end
        end
        return res;
    endfunction

    // Seven parity bits for a data word; bit 6 covers data and bits 5:0.
    function automatic logic [6:0] encode(input logic [31:0] d);
        logic [6:0] p;
        logic [5:0] pos;
        p = '0;
        for (int unsigned j = 0; j < 32; j++) begin
            pos = data_pos(j);
            for (int unsigned i = 0; i < 6; i++) begin
                if (pos[i]) p[i] = p[i] ^ d[j];
            end
        end
        p[6] = (^d) ^ (^p[5:0]);
        return p;
    endfunction

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_data_q, out_data_d;
    logic              out_ce_q, out_ce_d;
    logic              out_ue_q, out_ue_d;
    logic              scrub_we_q, scrub_we_d;
    logic [8:0]        scrub_addr_q, scrub_addr_d;
    logic [31:0]       scrub_din_q, scrub_din_d;
    logic [6:0]        scrub_pin_q, scrub_pin_d;
    logic [CNT_W-1:0]  ce_cnt_q, ce_cnt_d;
    logic [CNT_W-1:0]  ue_cnt_q, ue_cnt_d;
    logic              ue_sticky_q, ue_sticky_d;

    logic [6:0]  recomp;
    logic [5:0]  syn;
    logic        ov;
    logic        is_ce, is_ue;
    logic [31:0] corrected;
    logic [6:0]  new_par;
    logic        accept;

    // Syndrome decode: classify the word and correct a single data-bit flip.
    always_comb begin
        recomp    = encode(in_data);
        syn       = recomp[5:0] ^ in_parity[5:0];
        ov        = (^in_data) ^ (^in_parity);
        corrected = in_data;
        is_ce     = 1'b0;
        is_ue     = 1'b0;
        if (syn == 6'd0) begin
            is_ce = ov;
        end else if (!ov) begin
            is_ue = 1'b1;
        end else if (syn > 6'd38) begin
            is_ue = 1'b1;
        end else begin
            // Power-of-two syndromes match no data position: check-bit error.
            is_ce = 1'b1;
            for (int unsigned j = 0; j < 32; j++) begin
                if (data_pos(j) == syn) corrected[j] = ~in_data[j];
            end
        end
        new_par = encode(corrected);
    end

    // Next-state for the FSM, result registers, scrub port and counters.
    always_comb begin
        accept       = in_valid && (state_q == IDLE);
        state_d      = IDLE;
        out_valid_d  = accept;
        out_ce_d     = accept && is_ce;
        out_ue_d     = accept && is_ue;
        out_data_d   = accept ? corrected : out_data_q;
        scrub_we_d   = accept && is_ce && SCRUB_EN;
        scrub_addr_d = scrub_addr_q;
        scrub_din_d  = scrub_din_q;
        scrub_pin_d  = scrub_pin_q;
        if (scrub_we_d) begin
            state_d      = SCRUB;
            scrub_addr_d = in_addr;
            scrub_din_d  = corrected;
            scrub_pin_d  = new_par;
        end

        ce_cnt_d    = ce_cnt_q;
        ue_cnt_d    = ue_cnt_q;
        ue_sticky_d = ue_sticky_q;
        if (clr_cnt) begin
            ce_cnt_d    = '0;
            ue_cnt_d    = '0;
            ue_sticky_d = 1'b0;
        end else begin
            if (out_ce_d && (ce_cnt_q != '1)) ce_cnt_d = ce_cnt_q + CNT_W'(1);
            if (out_ue_d && (ue_cnt_q != '1)) ue_cnt_d = ue_cnt_q + CNT_W'(1);
            if (out_ue_d) ue_sticky_d = 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ce_q     <= 1'b0;
            out_ue_q     <= 1'b0;
            scrub_we_q   <= 1'b0;
            scrub_addr_q <= '0;
            scrub_din_q  <= '0;
            scrub_pin_q  <= '0;
            ce_cnt_q     <= '0;
            ue_cnt_q     <= '0;
            ue_sticky_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ce_q     <= out_ce_d;
            out_ue_q     <= out_ue_d;
            scrub_we_q   <= scrub_we_d;
            scrub_addr_q <= scrub_addr_d;
            scrub_din_q  <= scrub_din_d;
            scrub_pin_q  <= scrub_pin_d;
            ce_cnt_q     <= ce_cnt_d;
            ue_cnt_q     <= ue_cnt_d;
            ue_sticky_q  <= ue_sticky_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_ce     = out_ce_q;
    assign out_ue     = out_ue_q;
    // Reset asserted during the scrub cycle must suppress the array write
    // that would otherwise be committed at the reset edge.
    assign scrub_we   = scrub_we_q & rst;
    assign scrub_addr = scrub_addr_q;
    assign scrub_din  = scrub_din_q;
    assign scrub_pin  = scrub_pin_q;
    assign ce_cnt     = ce_cnt_q;
    assign ue_cnt     = ue_cnt_q;
    assign ue_sticky  = ue_sticky_q;

endmodule

// File: tb/tb_ecc_load_decoder.sv
// Directed bench for ecc_load_decoder: a table of hand-encoded words plus
// sequences for backpressure, counter saturation/clear and reset mid-scrub.
module tb_ecc_load_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [8:0]  in_addr = '0;
    logic [31:0] in_data = '0;
    logic [6:0]  in_parity = '0;
    logic        clr_cnt = 1'b0;

    logic        in_ready, out_valid, out_ce, out_ue, scrub_we, ue_sticky;
    logic [31:0] out_data, scrub_din;
    logic [8:0]  scrub_addr;
    logic [6:0]  scrub_pin;
    logic [1:0]  ce_cnt, ue_cnt;

    logic        ns_in_ready, ns_out_valid, ns_out_ce, ns_out_ue, ns_scrub_we, ns_ue_sticky;
    logic [31:0] ns_out_data, ns_scrub_din;
    logic [8:0]  ns_scrub_addr;
    logic [6:0]  ns_scrub_pin;
    logic [15:0] ns_ce_cnt, ns_ue_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ecc_load_decoder #(.CNT_W(2), .SCRUB_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .in_parity(in_parity),
        .out_valid(out_valid), .out_data(out_data), .out_ce(out_ce), .out_ue(out_ue),
        .scrub_we(scrub_we), .scrub_addr(scrub_addr), .scrub_din(scrub_din),
        .scrub_pin(scrub_pin), .clr_cnt(clr_cnt), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt),
        .ue_sticky(ue_sticky)
    );

    ecc_load_decoder #(.CNT_W(16), .SCRUB_EN(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ns_in_ready),
        .in_addr(in_addr), .in_data(in_data), .in_parity(in_parity),
        .out_valid(ns_out_valid), .out_data(ns_out_data), .out_ce(ns_out_ce),
        .out_ue(ns_out_ue), .scrub_we(ns_scrub_we), .scrub_addr(ns_scrub_addr),
        .scrub_din(ns_scrub_din), .scrub_pin(ns_scrub_pin), .clr_cnt(clr_cnt),
        .ce_cnt(ns_ce_cnt), .ue_cnt(ns_ue_cnt), .ue_sticky(ns_ue_sticky)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] data;
        logic [6:0]  par;
        logic [31:0] exp_data;
        logic        exp_ce;
        logic        exp_ue;
        logic [6:0]  exp_pin;
    } vec_t;

    vec_t vecs[14];

    initial begin
        // addr, data, parity, expected data, ce, ue, re-encoded parity
        vecs[0]  = '{9'h001, 32'h0000_0001, 7'h43, 32'h0000_0001, 1'b0, 1'b0, 7'h00}; // clean
        vecs[1]  = '{9'h002, 32'h0000_0000, 7'h00, 32'h0000_0000, 1'b0, 1'b0, 7'h00}; // clean zero
        vecs[2]  = '{9'h05A, 32'h0000_0001, 7'h00, 32'h0000_0000, 1'b1, 1'b0, 7'h00}; // d0 flip, s=3
        vecs[3]  = '{9'h003, 32'h0000_0000, 7'h01, 32'h0000_0000, 1'b1, 1'b0, 7'h00}; // check bit 0
        vecs[4]  = '{9'h004, 32'h0000_0000, 7'h40, 32'h0000_0000, 1'b1, 1'b0, 7'h00}; // parity[6]
        vecs[5]  = '{9'h005, 32'h0000_0003, 7'h00, 32'h0000_0003, 1'b0, 1'b1, 7'h00}; // double, s=6
        vecs[6]  = '{9'h006, 32'h0000_0000, 7'h7F, 32'h0000_0000, 1'b0, 1'b1, 7'h00}; // s=63 > 38
        vecs[7]  = '{9'h107, 32'h8000_0000, 7'h00, 32'h0000_0000, 1'b1, 1'b0, 7'h00}; // d31, s=38
        vecs[8]  = '{9'h108, 32'h8000_0000, 7'h26, 32'h8000_0000, 1'b0, 1'b0, 7'h00}; // clean d31
        vecs[9]  = '{9'h1A9, 32'h8000_0001, 7'h26, 32'h8000_0000, 1'b1, 1'b0, 7'h26}; // d0 flip on d31 word
        vecs[10] = '{9'h0AA, 32'h0000_0001, 7'h47, 32'h0000_0001, 1'b1, 1'b0, 7'h43}; // check bit 2
        vecs[11] = '{9'h0BB, 32'h0000_0000, 7'h03, 32'h0000_0000, 1'b0, 1'b1, 7'h00}; // two check bits
        vecs[12] = '{9'h0CC, 32'h0000_0400, 7'h00, 32'h0000_0000, 1'b1, 1'b0, 7'h00}; // d10, s=15
        vecs[13] = '{9'h0DD, 32'h0000_0400, 7'h4F, 32'h0000_0400, 1'b0, 1'b0, 7'h00}; // clean d10

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_scrub_we", scrub_we, 1'b0);
        chk("rst_ce_cnt", ce_cnt, 2'd0);
        chk("rst_ue_sticky", ue_sticky, 1'b0);
        rst = 1'b1;

        // Table of single reads
        for (int i = 0; i < 14; i++) begin
            int n;
            @(negedge clk);
            chk("idle_out_valid", out_valid, 1'b0);
            n = 0;
            while (!in_ready && n < 8) begin
                @(negedge clk);
                n++;
            end
            chk("ready_wait", in_ready, 1'b1);
            in_valid  = 1'b1;
            in_addr   = vecs[i].addr;
            in_data   = vecs[i].data;
            in_parity = vecs[i].par;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d_out_valid", i), out_valid, 1'b1);
            chk($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_data);
            chk($sformatf("v%0d_out_ce", i), out_ce, vecs[i].exp_ce);
            chk($sformatf("v%0d_out_ue", i), out_ue, vecs[i].exp_ue);
            chk($sformatf("v%0d_scrub_we", i), scrub_we, vecs[i].exp_ce);
            chk($sformatf("v%0d_in_ready", i), in_ready, !vecs[i].exp_ce);
            if (vecs[i].exp_ce) begin
                chk($sformatf("v%0d_scrub_addr", i), scrub_addr, vecs[i].addr);
                chk($sformatf("v%0d_scrub_din", i), scrub_din, vecs[i].exp_data);
                chk($sformatf("v%0d_scrub_pin", i), scrub_pin, vecs[i].exp_pin);
            end
            chk($sformatf("v%0d_ns_out_data", i), ns_out_data, vecs[i].exp_data);
            chk($sformatf("v%0d_ns_out_ce", i), ns_out_ce, vecs[i].exp_ce);
            chk($sformatf("v%0d_ns_out_ue", i), ns_out_ue, vecs[i].exp_ue);
            chk($sformatf("v%0d_ns_scrub_we", i), ns_scrub_we, 1'b0);
            chk($sformatf("v%0d_ns_in_ready", i), ns_in_ready, 1'b1);
        end

        // 7 CEs and 3 UEs: 2-bit counters saturate, 16-bit counters do not
        @(negedge clk);
        chk("sat_ce_cnt", ce_cnt, 2'd3);
        chk("sat_ue_cnt", ue_cnt, 2'd3);
        chk("sat_ue_sticky", ue_sticky, 1'b1);
        chk("ns_ce_cnt", ns_ce_cnt, 16'd7);
        chk("ns_ue_cnt", ns_ue_cnt, 16'd3);

        // Plain clear
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        chk("clr_ce_cnt", ce_cnt, 2'd0);
        chk("clr_ue_cnt", ue_cnt, 2'd0);
        chk("clr_ue_sticky", ue_sticky, 1'b0);

        // One CE counts, then a CE coincident with clr_cnt is dropped
        in_valid = 1'b1; in_addr = 9'h05A; in_data = 32'h1; in_parity = 7'h00;
        @(negedge clk);
        in_valid = 1'b0;
        chk("cnt1_ce_cnt", ce_cnt, 2'd1);
        @(negedge clk);
        in_valid = 1'b1; clr_cnt = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; clr_cnt = 1'b0;
        chk("clrce_out_ce", out_ce, 1'b1);
        chk("clrce_ce_cnt", ce_cnt, 2'd0);
        @(negedge clk);

        // Back-to-back: CE then clean with in_valid held high
        in_valid = 1'b1; in_addr = 9'h05A; in_data = 32'h1; in_parity = 7'h00;
        @(negedge clk);
        chk("b2b_first_valid", out_valid, 1'b1);
        chk("b2b_first_ce", out_ce, 1'b1);
        chk("b2b_scrub_we", scrub_we, 1'b1);
        chk("b2b_ready_low", in_ready, 1'b0);
        in_addr = 9'h011; in_data = 32'h1; in_parity = 7'h43;
        @(negedge clk);
        chk("b2b_gap_valid", out_valid, 1'b0);
        chk("b2b_gap_scrub_we", scrub_we, 1'b0);
        chk("b2b_ready_back", in_ready, 1'b1);
        chk("b2b_ns_valid", ns_out_valid, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_second_valid", out_valid, 1'b1);
        chk("b2b_second_data", out_data, 32'h1);
        chk("b2b_second_ce", out_ce, 1'b0);

        // UE to set sticky, then reset asserted during a scrub cycle
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h3; in_parity = 7'h00;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ue_sticky_set", ue_sticky, 1'b1);
        chk("ue_cnt_one", ue_cnt, 2'd1);
        chk("ue_no_scrub", scrub_we, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_addr = 9'h1FF; in_data = 32'h8000_0001; in_parity = 7'h26;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rs_scrub_we_before", scrub_we, 1'b1);
        chk("rs_scrub_addr_before", scrub_addr, 9'h1FF);
        rst = 1'b0;
        #1;
        chk("rs_scrub_we_abort", scrub_we, 1'b0);
        @(negedge clk);
        chk("rs_scrub_we", scrub_we, 1'b0);
        chk("rs_in_ready", in_ready, 1'b1);
        chk("rs_out_valid", out_valid, 1'b0);
        chk("rs_out_ce", out_ce, 1'b0);
        chk("rs_out_data", out_data, 32'h0);
        chk("rs_scrub_addr", scrub_addr, 9'h0);
        chk("rs_scrub_din", scrub_din, 32'h0);
        chk("rs_scrub_pin", scrub_pin, 7'h0);
        chk("rs_ce_cnt", ce_cnt, 2'd0);
        chk("rs_ue_cnt", ue_cnt, 2'd0);
        chk("rs_ue_sticky", ue_sticky, 1'b0);
        chk("rs_ns_ce_cnt", ns_ce_cnt, 16'd0);
        rst = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ecc_load_decoder.md
# ecc_load_decoder

SECDED(39,32) load-path decoder and scrubber for the data cache. It sits between the cache data/parity arrays and the MEM-stage load result. It checks every word read from the arrays against the 7 parity bits produced by the store-side encoder, and returns corrected data with error flags. On a correctable error it writes the corrected word and re-encoded parity back to the array (scrub) and holds off new reads while doing so. It also keeps saturating error counters.

## Interface

- CNT_W, 16, width of error counters
- SCRUB_EN, 1, 1 = write back corrected words; 0 = correct only, never assert scrub_we
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset (rst==0 resets)
- in_valid  in  1  array read word presented this cycle
- in_ready  out  1  decoder can accept in_valid
- in_addr  in  9  array word address of the read
- in_data  in  32  stored data word
- in_parity  in  7  stored parity bits
- out_valid  out  1  one-cycle pulse, decoded result valid
- out_data  out  32  corrected data
- out_ce  out  1  single-bit error corrected (data or check bit)
- out_ue  out  1  uncorrectable error detected
- scrub_we  out  1  one-cycle write-back strobe
- scrub_addr  out  9  write-back address
- scrub_din  out  32  corrected data
- scrub_pin  out  7  re-encoded parity
- clr_cnt  in  1  clear both counters
- ce_cnt  out  CNT_W  corrected-error count, saturating
- ue_cnt  out  CNT_W  uncorrectable-error count, saturating
- ue_sticky  out  1  set on any UE, cleared by clr_cnt or reset

## Operation

- Code: Hamming positions 1..38. Check bit i sits at position 2^i (i=0..5). Data d0..d31 fill the non-power-of-two positions 3,5,6,7,9..38 in ascending order.
- Parity: parity[i] (i=0..5) is even parity over data bits whose position has bit i set. parity[6] is even parity over all 32 data bits plus parity[5:0].
- Decode: syndrome s[5:0] = recomputed parity[5:0] XOR in_parity[5:0]. ov = XOR of all in_data and all in_parity bits.
- Decode cases:
  - s==0, ov==0: clean.
  - ov==1, s==0: parity[6] error. CE, data unchanged.
  - ov==1, s a power of two: check-bit error. CE, data unchanged.
  - ov==1, s a data position ≤38: flip that data bit. CE.
  - ov==1, s>38: UE.
  - ov==0, s!=0: UE (double error).
- On UE, out_data = in_data unmodified, and no scrub is performed.
- FSM has two states, IDLE and SCRUB.
  - IDLE: in_ready=1. An accepted in_valid that decodes to CE with SCRUB_EN=1 moves the FSM to SCRUB.
  - SCRUB: in_ready=0 and scrub_we=1 for exactly one cycle, carrying the corrected data and freshly encoded parity. The FSM then returns to IDLE.
- in_valid is ignored while in_ready=0. Upstream holds the request.
- Counters: ce_cnt +1 per CE result and ue_cnt +1 per UE result. Both hold at 2^CNT_W−1.
- clr_cnt has priority over an increment in the same cycle: the count becomes 0 and that event is dropped.

## Timing

- Reset (rst==0 at clk edge) forces:
  - FSM to IDLE.
  - out_valid, out_ce, out_ue, scrub_we, ue_sticky to 0.
  - out_data, scrub_addr, scrub_din, scrub_pin, ce_cnt, ue_cnt to 0.
  - in_ready to 1 from the first cycle after reset.
- Reset during SCRUB aborts the write-back. No scrub_we is issued.
- Latency: in_valid accepted at edge N gives out_valid/out_data/out_ce/out_ue registered at edge N+1, pulsed for one cycle.
- Scrub: scrub_we is high in the same cycle as out_valid (after edge N+1), and in_ready is low in that cycle. The next read can be accepted at edge N+2.
- Throughput: one word per cycle when clean or UE; one word per two cycles when scrubbing.
- Counters and ue_sticky update at the same edge as out_valid.

## Test plan

- Clean word: in_data=32'h0000_0001, in_parity=7'h43 → next cycle out_valid=1, out_data=32'h0000_0001, out_ce=0, out_ue=0, no scrub_we, in_ready stays 1.
- Single data error: in_addr=9'h05A, in_data=32'h0000_0001, in_parity=7'h00 (s=3, ov=1) → out_data=0, out_ce=1, scrub_we pulse with scrub_addr=9'h05A, scrub_din=0, scrub_pin=0; in_ready=0 for that cycle; ce_cnt=1.
- Check-bit error: in_data=0, in_parity=7'h01 → out_data=0, out_ce=1, scrub_pin=7'h00. With SCRUB_EN=0: same out_ce=1, no scrub_we, in_ready stays 1.
- Double error: in_data=32'h0000_0003, in_parity=7'h00 (s=6, ov=0) → out_ue=1, out_data=32'h0000_0003, ue_cnt=1, ue_sticky=1, no scrub.
- Back-to-back and backpressure: in_valid held high for CE, then clean → second word accepted only after the scrub cycle; its out_valid is exactly 2 cycles after the first.
- Counters and reset: with CNT_W=2, 5 CEs → ce_cnt=3. Then clr_cnt coincident with a CE → ce_cnt=0. Then rst=0 asserted in the SCRUB cycle → scrub_we=0 and all outputs at reset values.
